truth_table_sweeper: RTL



---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_misr.sv | 41 ++++
 rtl/truth_table_sweeper.sv | 127 ++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper: FSM state encoding,
// default MISR feedback mask and a counter-width helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] DEFAULT_SIG_TAPS = 16'hB400;

  // A one-cycle hold still needs a 1-bit counter so the hold logic stays regular.
  function automatic int hold_cnt_width(input int hold_cycles);
    return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_misr.sv
// Multiple-input signature register: shift left with parity feedback of the
// tapped bits, then XOR in the zero-extended response word.
module misr_reg
  import truth_table_sweeper_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter int               DIN_W    = 4,
  parameter logic [SIG_W-1:0] SIG_TAPS = SIG_W'(DEFAULT_SIG_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // clear and en are never asserted together by the sweeper; clear wins anyway.
  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], ^(sig_q & SIG_TAPS)} ^ SIG_W'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector to a combinational DUT, holds
// it HOLD_CYCLES clocks, and compacts the responses into a MISR signature.
// Define SWEEP_GRAY_EN to drive vectors in Gray order instead of binary order.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int               IN_W        = 4,
  parameter int               OUT_W       = 4,
  parameter int               HOLD_CYCLES = 10,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] SIG_TAPS    = SIG_W'(DEFAULT_SIG_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  stim,
  output logic             sample_valid,
  output logic [IN_W-1:0]  sample_idx,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [1:0]       state_dbg
);

  localparam int              HW        = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IN_W-1:0] IDX_LAST  = {IN_W{1'b1}};
  localparam logic            SV_FIRST  = (HOLD_CYCLES == 1);

  state_e          state_q;
  logic [IN_W-1:0] idx_q;
  logic [HW-1:0]   hold_q;
  logic [IN_W-1:0] stim_q;
  logic            sample_valid_q;
  logic            busy_q;
  logic            done_q;

  logic [IN_W-1:0] idx_inc;
  logic [HW-1:0]   hold_inc;
  logic            launch;

  assign idx_inc  = idx_q + 1'b1;
  assign hold_inc = hold_q + 1'b1;
  assign launch   = start && (state_q == S_IDLE || state_q == S_DONE);

  function automatic logic [IN_W-1:0] encode(input logic [IN_W-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // sample_valid is a one-cycle qualifier with no back-pressure: dut_out is
  // captured into the MISR at the rising edge that ends a sample_valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      hold_q         <= '0;
      stim_q         <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_DRIVE;
            idx_q          <= '0;
            hold_q         <= '0;
            stim_q         <= encode('0);
            sample_valid_q <= SV_FIRST;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            if (idx_q == IDX_LAST) begin
              // The MISR takes the final response on this same edge.
              state_q        <= S_DONE;
              idx_q          <= '0;
              stim_q         <= '0;
              sample_valid_q <= 1'b0;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
            end else begin
              idx_q          <= idx_inc;
              stim_q         <= encode(idx_inc);
              sample_valid_q <= SV_FIRST;
            end
          end else begin
            hold_q         <= hold_inc;
            sample_valid_q <= (hold_inc == HOLD_LAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  misr_reg #(
    .SIG_W   (SIG_W),
    .DIN_W   (OUT_W),
    .SIG_TAPS(SIG_TAPS)
  ) u_misr (
    .clk  (clk),
    .reset(reset),
    .clear(launch),
    .en   (sample_valid_q),
    .din  (dut_out),
    .sig  (signature)
  );

  assign stim         = stim_q;
  assign sample_valid = sample_valid_q;
  assign sample_idx   = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule
